// File: rtl/blind_level_ctrl.sv
// blind_level_ctrl: multi-level motorised blind controller with commanded or light-driven target.
// Latency: command/sensor sampled at edge k -> motor output changes at edge k+1.
// Backpressure: none; commands are single-cycle strobes, dropped while in FAULT.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   cmd_valid/auto/level   command strobe, auto-mode request, target level
//   light                  ambient light code used in auto mode
//   pos_sens               position sensors, one-hot when legal (0 = bottom)
//   fault_clr              leaves FAULT; target is reset to the current level
//   motor_up/motor_down    motor drive, never both high
//   busy, fault            state is MOVE_* / FAULT
//   cur_level, auto_mode   last legally sensed level, auto mode active
//   tick                   one-cycle prescaler pulse
//
// Optional feature: define BLIND_WATCHDOG_EN to build the tick-based motion watchdog.
module blind_level_ctrl #(
  parameter int LEVELS        = 3,
  parameter int PRESCALE_W    = 25,
  parameter int TIMEOUT_TICKS = 8,
  localparam int LW           = $clog2(LEVELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_auto,
  input  logic [LW-1:0]     cmd_level,
  input  logic [1:0]        light,
  input  logic [LEVELS-1:0] pos_sens,
  input  logic              fault_clr,
  output logic              motor_up,
  output logic              motor_down,
  output logic              busy,
  output logic [LW-1:0]     cur_level,
  output logic              auto_mode,
  output logic              fault,
  output logic              tick
);

  localparam logic [LW-1:0] TOP = LW'(LEVELS - 1);
  localparam logic [LW-1:0] MID = LW'(LEVELS / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DEAD,
    S_FAULT
  } state_t;

  state_t                  state;
  logic [PRESCALE_W-1:0]   presc;
  logic [LEVELS-1:0]       ps_q;
  logic [LW-1:0]           target;

  logic                    ps_multi;
  logic                    ps_onehot;
  logic [LW-1:0]           ps_idx;
  logic                    want_up;
  logic                    want_down;
  logic                    timeout_hit;
  logic [LW-1:0]           cmd_clamped;
  logic [LW-1:0]           auto_tgt;

  // ---------------------------------------------------------------------------
  // Prescaler and sensor sampling
  // ---------------------------------------------------------------------------
  assign tick = &presc;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      ps_q      <= '0;
      cur_level <= '0;
    end else begin
      presc <= presc + 1'b1;
      ps_q  <= pos_sens;
      // An all-zero pattern (blind between sensors) keeps the last level.
      if (ps_onehot) cur_level <= ps_idx;
    end
  end

  always_comb begin
    ps_idx = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (ps_q[i]) ps_idx = LW'(i);
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means two or more sensors.
  assign ps_multi  = |(ps_q & (ps_q - 1'b1));
  assign ps_onehot = (ps_q != '0) && !ps_multi;

  // ---------------------------------------------------------------------------
  // Target and auto mode
  // ---------------------------------------------------------------------------
  assign cmd_clamped = (cmd_level > TOP) ? TOP : cmd_level;
  assign auto_tgt    = light[1] ? TOP : (light[0] ? MID : '0);
  assign want_up     = target > cur_level;
  assign want_down   = target < cur_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      target    <= '0;
      auto_mode <= 1'b0;
    end else if (state == S_FAULT) begin
      // Commands are dropped here. On exit, park the target on the level the
      // blind is at now (including a level being latched this very edge).
      if (fault_clr && !ps_multi) target <= ps_onehot ? ps_idx : cur_level;
    end else if (cmd_valid && !cmd_auto) begin
      auto_mode <= 1'b0;
      target    <= cmd_clamped;
    end else begin
      if (cmd_valid) auto_mode <= 1'b1;
      if (auto_mode && tick) target <= auto_tgt;
    end
  end

  // ---------------------------------------------------------------------------
  // Motion watchdog
  // ---------------------------------------------------------------------------
`ifdef BLIND_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_TICKS + 1);

  logic [WDW-1:0] wd;
  logic           moving;
  logic           lvl_change;

  assign moving     = (state == S_UP) || (state == S_DOWN);
  assign lvl_change = ps_onehot && (ps_idx != cur_level);

  always_ff @(posedge clk) begin
    if (reset || !moving || lvl_change) begin
      wd <= '0;
    end else if (tick) begin
      wd <= wd + 1'b1;
    end
  end

  // A level change in the same cycle is proof of motion, so it wins over the tick.
  assign timeout_hit = moving && tick && !lvl_change && (wd == WDW'(TIMEOUT_TICKS - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM. Outputs are registered from the next state; the limit
  // sensors gate the motor bits so the drive can never push past an end stop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      case (state)
        // DEAD shares IDLE's direction decision so the off gap is one cycle.
        S_IDLE, S_DEAD: begin
          if (ps_multi) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else if (want_up) begin
            state    <= S_UP;
            busy     <= 1'b1;
            motor_up <= !ps_q[LEVELS-1];
          end else if (want_down) begin
            state      <= S_DOWN;
            busy       <= 1'b1;
            motor_down <= !ps_q[0];
          end else begin
            state <= S_IDLE;
          end
        end
        S_UP: begin
          if (ps_multi || timeout_hit) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else if (ps_q[target]) begin
            state <= S_IDLE;
          end else if (!want_up) begin
            state <= S_DEAD;
          end else begin
            busy     <= 1'b1;
            motor_up <= !ps_q[LEVELS-1];
          end
        end
        S_DOWN: begin
          if (ps_multi || timeout_hit) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else if (ps_q[target]) begin
            state <= S_IDLE;
          end else if (!want_down) begin
            state <= S_DEAD;
          end else begin
            busy       <= 1'b1;
            motor_down <= !ps_q[0];
          end
        end
        S_FAULT: begin
          if (fault_clr && !ps_multi) begin
            state <= S_IDLE;
          end else begin
            fault <= 1'b1;
          end
        end
        default: begin
          state <= S_FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blind_level_ctrl.sv
// tb_blind_level_ctrl: directed test of blind_level_ctrl (LEVELS=3, PRESCALE_W=3, TIMEOUT_TICKS=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_blind_level_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_auto;
  logic [1:0] cmd_level;
  logic [1:0] light;
  logic [2:0] pos_sens;
  logic       fault_clr;
  logic       motor_up;
  logic       motor_down;
  logic       busy;
  logic [1:0] cur_level;
  logic       auto_mode;
  logic       fault;
  logic       tick;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  blind_level_ctrl #(
    .LEVELS       (3),
    .PRESCALE_W   (3),
    .TIMEOUT_TICKS(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_auto  (cmd_auto),
    .cmd_level (cmd_level),
    .light     (light),
    .pos_sens  (pos_sens),
    .fault_clr (fault_clr),
    .motor_up  (motor_up),
    .motor_down(motor_down),
    .busy      (busy),
    .cur_level (cur_level),
    .auto_mode (auto_mode),
    .fault     (fault),
    .tick      (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_level(input logic [1:0] lvl);
    cmd_valid = 1'b1;
    cmd_auto  = 1'b0;
    cmd_level = lvl;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (!tick && n < 16) begin
      step(1);
      n++;
    end
    check(tag, tick, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL tb_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first;
    int second;
    int cnt;
    int nt;
    logic seen;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_auto  = 1'b0;
    cmd_level = 2'd0;
    light     = 2'b00;
    pos_sens  = 3'b001;
    fault_clr = 1'b0;

    // Reset state
    step(2);
    check("rst_motor_up", motor_up, 0);
    check("rst_motor_down", motor_down, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_auto", auto_mode, 0);
    check("rst_level", cur_level, 0);
    check("rst_tick", tick, 0);
    reset = 1'b0;

    // Tick every 8 cycles, first one 7 cycles after release
    first = -1; second = -1; cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (tick) begin
        cnt++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("tick_first", first, 7);
    check("tick_period", second - first, 8);
    check("tick_count", cnt, 2);

    // Up move 0 -> 2
    send_level(2'd2);
    check("up_not_yet", motor_up, 0);
    step(1);
    check("up_start", motor_up, 1);
    check("up_busy", busy, 1);
    pos_sens = 3'b010;
    step(2);
    check("up_pass_lvl1", cur_level, 1);
    check("up_still", motor_up, 1);
    pos_sens = 3'b100;
    step(1);
    check("up_one_edge", motor_up, 1);
    step(1);
    check("up_stop", motor_up, 0);
    check("up_level", cur_level, 2);
    check("up_idle", busy, 0);

    // Down move 2 -> 0
    send_level(2'd0);
    step(1);
    check("down_start", motor_down, 1);
    check("down_no_up", motor_up, 0);
    pos_sens = 3'b010;
    step(2);
    pos_sens = 3'b001;
    step(2);
    check("down_stop", motor_down, 0);
    check("down_level", cur_level, 0);

    // Reversal while moving up from level 1
    send_level(2'd2);
    step(1);
    pos_sens = 3'b010;
    step(2);
    check("rev_level", cur_level, 1);
    send_level(2'd0);
    check("rev_up_before", motor_up, 1);
    step(1);
    check("rev_dead_up", motor_up, 0);
    check("rev_dead_down", motor_down, 0);
    step(1);
    check("rev_down", motor_down, 1);
    check("rev_down_no_up", motor_up, 0);
    pos_sens = 3'b001;
    step(2);
    check("rev_arrive", busy, 0);

    // Auto mode: light 01 -> level 1, light 00 -> level 0
    light     = 2'b01;
    cmd_valid = 1'b1;
    cmd_auto  = 1'b1;
    step(1);
    cmd_valid = 1'b0;
    cmd_auto  = 1'b0;
    check("auto_on", auto_mode, 1);
    wait_tick("auto_tick1");
    step(1);
    check("auto_wait", motor_up, 0);
    step(1);
    check("auto_up", motor_up, 1);
    pos_sens = 3'b010;
    step(2);
    check("auto_arrive", motor_up, 0);
    check("auto_level", cur_level, 1);
    light = 2'b00;
    wait_tick("auto_tick2");
    step(2);
    check("auto_down", motor_down, 1);
    pos_sens = 3'b001;
    step(2);
    send_level(2'd0);
    check("auto_off", auto_mode, 0);

    // Out-of-range command clamps to the top level
    send_level(2'd3);
    step(1);
    check("clamp_up", motor_up, 1);
    pos_sens = 3'b010;
    step(2);
    check("clamp_mid", motor_up, 1);
    pos_sens = 3'b100;
    step(2);
    check("clamp_idle", busy, 0);
    check("clamp_level", cur_level, 2);

    // Illegal sensor pattern -> FAULT, commands ignored, clear without restart
    pos_sens = 3'b011;
    step(2);
    check("flt_set", fault, 1);
    check("flt_up", motor_up, 0);
    check("flt_busy", busy, 0);
    check("flt_level_hold", cur_level, 2);
    send_level(2'd0);
    step(2);
    check("flt_ignore_cmd", motor_down, 0);
    check("flt_stay", fault, 1);
    pos_sens = 3'b010;
    step(2);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("flt_clear", fault, 0);
    check("flt_clr_level", cur_level, 1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      seen = seen | motor_up | motor_down | busy;
    end
    check("flt_no_restart", seen, 0);

`ifdef BLIND_WATCHDOG_EN
    // Stuck sensor while moving -> FAULT on the 4th tick
    send_level(2'd2);
    step(1);
    check("wd_moving", motor_up, 1);
    nt = 0;
    for (int i = 0; i < 80 && !fault; i++) begin
      if (tick) nt++;
      step(1);
    end
    check("wd_fault", fault, 1);
    check("wd_ticks", nt, 4);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("wd_clear", fault, 0);
`else
    // Without the watchdog a stuck sensor never faults
    nt = 0;
    send_level(2'd2);
    step(40);
    check("nowd_no_fault", fault, 0);
    check("nowd_moving", motor_up, 1);
    pos_sens = 3'b100;
    step(2);
    check("nowd_arrive", busy, 0);
`endif

    // Bottom limit: sensor 0 already set as a down move starts
    pos_sens = 3'b001;
    send_level(2'd0);
    seen = motor_down;
    for (int i = 0; i < 4; i++) begin
      step(1);
      seen = seen | motor_down;
    end
    check("limit_down", seen, 0);
    check("limit_down_lvl", cur_level, 0);
    check("limit_down_idle", busy, 0);

    // Top limit: sensor 2 set while MOVE_UP is entered
    pos_sens = 3'b100;
    send_level(2'd2);
    seen = motor_up;
    for (int i = 0; i < 4; i++) begin
      step(1);
      seen = seen | motor_up;
    end
    check("limit_up", seen, 0);
    check("limit_up_lvl", cur_level, 2);
    check("limit_up_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
